// File: rtl/capture_readout_sequencer.sv
// Capture/readout sequencer: arms all channel write controllers, waits for every
// channel FIFO to fill, then drains channel 0..NUM_CH-1 as one AXI-Stream packet each.
module capture_readout_sequencer #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned TIMEOUT = 2**20
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       arm,
  input  logic                       abort,
  output logic                       wc_start,
  input  logic [NUM_CH-1:0]          ch_full,
  input  logic [NUM_CH-1:0]          ch_empty,
  input  logic [NUM_CH*DATA_W-1:0]   ch_dout,
  output logic [NUM_CH-1:0]          ch_rd_en,
  output logic [DATA_W-1:0]          m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast,
  output logic [$clog2(NUM_CH)-1:0]  m_tuser,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err
);

  localparam int unsigned SW = $clog2(NUM_CH);
  localparam int unsigned WW = $clog2(DEPTH);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_FULL,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          wc_start_q, wc_start_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          hs;

  // Stream datapath is a pure function of the selected channel; abort masks the
  // handshake so no word is popped from a FIFO without being accepted downstream.
  always_comb begin
    m_tdata  = '0;
    m_tuser  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    ch_rd_en = '0;
    if (state_q == S_DRAIN) begin
      m_tdata  = ch_dout[sel_q*DATA_W +: DATA_W];
      m_tuser  = sel_q;
      m_tvalid = ~ch_empty[sel_q] & ~abort;
      m_tlast  = (wcnt_q == WW'(DEPTH - 1));
    end
    hs = m_tvalid & m_tready;
    if (hs) begin
      ch_rd_en[sel_q] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wcnt_d  = wcnt_q;
    timer_d = timer_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_START;
          err_d   = 1'b0;
        end
      end
      S_START: begin
        state_d = S_WAIT_FULL;
        timer_d = '0;
      end
      S_WAIT_FULL: begin
        if (&ch_full) begin
          state_d = S_DRAIN;
          sel_d   = '0;
          wcnt_d  = '0;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DRAIN: begin
        if (hs) begin
          if (m_tlast) begin
            wcnt_d = '0;
            if (sel_q == SW'(NUM_CH - 1)) begin
              state_d = S_DONE;
            end else begin
              sel_d = sel_q + SW'(1);
            end
          end else begin
            wcnt_d = wcnt_q + WW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // abort wins over arm and over a same-cycle timeout; the error flag is left as it was
    if (abort) begin
      state_d = S_IDLE;
      err_d   = err_q;
    end
    wc_start_d = (state_d == S_START);
    done_d     = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      wcnt_q     <= '0;
      timer_q    <= '0;
      wc_start_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      wcnt_q     <= wcnt_d;
      timer_q    <= timer_d;
      wc_start_q <= wc_start_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign wc_start    = wc_start_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_capture_readout_sequencer.sv
// Bench for capture_readout_sequencer: queue-based FWFT FIFO and write-controller
// models feed the DUT; a negedge monitor scores the stream against per-channel queues.
`timescale 1ns/1ps
module tb_capture_readout_sequencer;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 100;
  localparam int unsigned SW      = $clog2(NUM_CH);
  localparam int unsigned FRAME   = NUM_CH * DEPTH;

  logic                      clk = 1'b0;
  logic                      rstn = 1'b0;
  logic                      arm = 1'b0;
  logic                      abort = 1'b0;
  logic                      m_tready = 1'b0;
  logic [NUM_CH-1:0]         ch_full = '0;
  logic [NUM_CH-1:0]         ch_empty = '1;
  logic [NUM_CH*DATA_W-1:0]  ch_dout = '0;
  logic [NUM_CH-1:0]         ch_rd_en;
  logic                      wc_start, m_tvalid, m_tlast, busy, done, timeout_err;
  logic [DATA_W-1:0]         m_tdata;
  logic [SW-1:0]             m_tuser;

  capture_readout_sequencer #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .arm        (arm),
    .abort      (abort),
    .wc_start   (wc_start),
    .ch_full    (ch_full),
    .ch_empty   (ch_empty),
    .ch_dout    (ch_dout),
    .ch_rd_en   (ch_rd_en),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .m_tuser    (m_tuser),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] fifo_q[NUM_CH][$];
  logic [DATA_W-1:0] exp_q[NUM_CH][$];
  int unsigned       wr_cnt[NUM_CH];
  int unsigned       wr_lim[NUM_CH];
  bit                wr_active[NUM_CH];

  int                checks = 0;
  int                errors = 0;
  int unsigned       ready_pct = 100;
  bit                gap_en = 1'b0;
  bit                gap = 1'b0;
  logic [NUM_CH-1:0] pop_mask = '0;
  bit                hold_pending = 1'b0;
  logic [DATA_W-1:0] hold_data = '0;
  logic [SW-1:0]     hold_user = '0;
  bit                prev_accept = 1'b0;
  bit                exp_done = 1'b0;
  int unsigned       frame_words = 0;
  int unsigned       done_cnt = 0;
  int unsigned       wc_cnt = 0;
  int unsigned       tmo_cnt = 0;
  bit                tmo_track = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic drive_fifo_outputs();
    for (int i = 0; i < NUM_CH; i++) begin
      ch_full[i]  = (fifo_q[i].size() == DEPTH);
      ch_empty[i] = (fifo_q[i].size() == 0) || gap;
      ch_dout[i*DATA_W +: DATA_W] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : '0;
    end
  endtask

  task automatic flush_model();
    for (int i = 0; i < NUM_CH; i++) begin
      fifo_q[i].delete();
      exp_q[i].delete();
      wr_active[i] = 1'b0;
      wr_cnt[i]    = 0;
      wr_lim[i]    = DEPTH;
    end
    gap_en   = 1'b0;
    gap      = 1'b0;
    pop_mask = '0;
    drive_fifo_outputs();
  endtask

  // FIFO + write-controller model: pops what the DUT read, pushes random fill words
  initial begin : drv
    logic [DATA_W-1:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (rstn) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (pop_mask[i] && fifo_q[i].size() != 0) void'(fifo_q[i].pop_front());
        end
      end
      pop_mask = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_active[i] && wr_cnt[i] < wr_lim[i] && $urandom_range(0, 1) == 1) begin
          w = DATA_W'($urandom);
          fifo_q[i].push_back(w);
          exp_q[i].push_back(w);
          wr_cnt[i]++;
        end
      end
      m_tready = ($urandom_range(0, 99) < ready_pct);
      gap      = gap_en && !hold_pending && ($urandom_range(0, 3) == 0);
      drive_fifo_outputs();
    end
  end

  // Monitor: every word must be the next one of channel frame_words/DEPTH
  initial begin : mon
    int unsigned       exp_ch;
    logic [NUM_CH-1:0] exp_rd;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_accept  = 1'b0;
        exp_done     = 1'b0;
        hold_pending = 1'b0;
        tmo_track    = 1'b0;
        pop_mask     = '0;
      end else begin
        check("wc_start", wc_start, prev_accept);
        if (prev_accept) check("timeout_err_cleared", timeout_err, 0);
        check("done", done, exp_done);
        exp_done = 1'b0;
        if (done) begin
          done_cnt++;
          tmo_track = 1'b0;
        end
        if (wc_start) begin
          wc_cnt++;
          frame_words = 0;
          tmo_track   = 1'b1;
          tmo_cnt     = 0;
          for (int i = 0; i < NUM_CH; i++) begin
            wr_active[i] = 1'b1;
            wr_cnt[i]    = 0;
          end
        end else if (tmo_track) begin
          tmo_cnt++;
          if (timeout_err) begin
            check("timeout_cycles", tmo_cnt, TIMEOUT + 1);
            tmo_track = 1'b0;
          end
        end
        exp_ch = frame_words / DEPTH;
        if (hold_pending && !abort) begin
          check("hold_tvalid", m_tvalid, 1);
          check("hold_tdata", m_tdata, hold_data);
          check("hold_tuser", m_tuser, hold_user);
        end
        if (m_tvalid && exp_ch >= NUM_CH) begin
          check("tvalid_after_frame", m_tvalid, 0);
        end else begin
          exp_rd = '0;
          if (m_tvalid && m_tready && !abort) exp_rd[exp_ch] = 1'b1;
          check(abort ? "rd_en_abort" : "rd_en", ch_rd_en, exp_rd);
          if (m_tvalid && !abort) begin
            check("tuser", m_tuser, exp_ch);
            check("tlast", m_tlast, (frame_words % DEPTH) == DEPTH - 1);
          end
          if (m_tvalid && m_tready && !abort) begin
            if (exp_q[exp_ch].size() == 0) begin
              check("word_without_fill", 1, 0);
            end else begin
              check("tdata", m_tdata, exp_q[exp_ch].pop_front());
            end
            frame_words++;
            if (frame_words == FRAME) exp_done = 1'b1;
          end
        end
        prev_accept  = arm && !busy && !abort;
        hold_pending = m_tvalid && !m_tready && !abort;
        hold_data    = m_tdata;
        hold_user    = m_tuser;
        pop_mask     = abort ? '0 : ch_rd_en;
      end
    end
  end

  task automatic pulse_arm();
    @(posedge clk);
    #1 arm = 1'b1;
    @(posedge clk);
    #1 arm = 1'b0;
  endtask

  task automatic wait_done(input string name, input int unsigned bound);
    int unsigned start = done_cnt;
    int unsigned n = 0;
    while (done_cnt == start && n < bound) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (done_cnt == start) begin
      errors++;
      $display("FAIL %s: no done within %0d cycles", name, bound);
    end
  endtask

  task automatic wait_words(input string name, input int unsigned base_wc, input int unsigned n);
    int unsigned k = 0;
    while (!(wc_cnt > base_wc && frame_words >= n) && k < 2000) begin
      @(negedge clk);
      #2;
      k++;
    end
    checks++;
    if (!(wc_cnt > base_wc && frame_words >= n)) begin
      errors++;
      $display("FAIL %s: %0d words not reached, got %0d", name, n, frame_words);
    end
  endtask

  task automatic run_frame(input string name, input int unsigned pct, input bit gaps);
    int unsigned w = wc_cnt;
    int unsigned left;
    ready_pct = pct;
    gap_en    = gaps;
    pulse_arm();
    wait_done(name, 3000);
    gap_en = 1'b0;
    check({name, "_wc_starts"}, wc_cnt - w, 1);
    check({name, "_words"}, frame_words, FRAME);
    left = 0;
    for (int i = 0; i < NUM_CH; i++) left += fifo_q[i].size();
    check({name, "_drained"}, left, 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_wc_start"}, wc_start, 0);
    check({name, "_rd_en"}, ch_rd_en, 0);
    check({name, "_tvalid"}, m_tvalid, 0);
    check({name, "_tlast"}, m_tlast, 0);
    check({name, "_tuser"}, m_tuser, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin : stim
    int unsigned w;
    int unsigned d;
    int unsigned k;
    flush_model();
    #2;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;

    run_frame("full_rate", 100, 1'b0);
    run_frame("rand_ready", 50, 1'b0);

    // arm while draining must be ignored
    w = wc_cnt;
    d = done_cnt;
    ready_pct = 70;
    pulse_arm();
    wait_words("arm_in_drain_a", w, 5);
    pulse_arm();
    wait_words("arm_in_drain_b", w, 30);
    pulse_arm();
    wait_done("arm_in_drain", 3000);
    repeat (20) @(negedge clk);
    #2;
    check("arm_in_drain_wc_starts", wc_cnt - w, 1);
    check("arm_in_drain_dones", done_cnt - d, 1);

    // channel 2 never fills: timeout, no reads, then cleared by the next arm
    w = wc_cnt;
    d = done_cnt;
    wr_lim[2] = DEPTH - 1;
    ready_pct = 100;
    pulse_arm();
    k = 0;
    while (!timeout_err && k < 400) begin
      @(negedge clk);
      #2;
      k++;
    end
    check("timeout_err_set", timeout_err, 1);
    check("timeout_busy", busy, 0);
    check("timeout_no_done", done_cnt - d, 0);
    @(negedge clk);
    #2 flush_model();
    run_frame("after_timeout", 100, 1'b0);
    check("after_timeout_err", timeout_err, 0);

    // async reset at word 7 of channel 1
    w = wc_cnt;
    ready_pct = 100;
    pulse_arm();
    wait_words("reset_mid_drain", w, DEPTH + 7);
    rstn = 1'b0;
    #1;
    check_all_zero("async_reset");
    flush_model();
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    #2;
    check("post_reset_busy", busy, 0);

    // abort together with arm in IDLE
    w = wc_cnt;
    @(posedge clk);
    #1;
    arm   = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    arm   = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("abort_arm_no_start", wc_cnt - w, 0);
    check("abort_arm_busy", busy, 0);

    run_frame("empty_gaps", 60, 1'b1);

    // abort in the middle of a drain
    w = wc_cnt;
    d = done_cnt;
    ready_pct = 100;
    pulse_arm();
    wait_words("abort_mid_drain", w, 20);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    #2;
    check("abort_drain_busy", busy, 0);
    check("abort_drain_no_done", done_cnt - d, 0);
    flush_model();
    run_frame("after_abort", 80, 1'b1);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
